// File: rtl/edecout_213_pkg.sv
// edecout_213_pkg: shared parameters and output word layout for the (2,1,3) decoder output stage
package edecout_213_pkg;
  localparam int K = 1;
  localparam int PACK_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int BLOCK_BITS_DEF = 256;
  localparam int NB_W = 4;
  // word layout, MSB first: {data, nbits, last, err}
  localparam int ERR_B = 0;
  localparam int LAST_B = 1;
  localparam int NB_LO = 2;
  localparam int DATA_LO = NB_LO + NB_W;
  function automatic int word_w(input int pack_w);
    return pack_w + NB_W + 2;
  endfunction
endpackage

// File: rtl/edecout_213_if.sv
// edecout_213_if: valid/ready word stream from the decoder output stage to the host
interface edecout_213_if
  import edecout_213_pkg::*;
#(
  parameter int PACK_W = PACK_W_DEF
) ();
  logic [PACK_W-1:0] out_data;
  logic [NB_W-1:0] out_nbits;
  logic out_last;
  logic out_err;
  logic out_valid;
  logic out_ready;
  modport master(output out_data, out_nbits, out_last, out_err, out_valid, input out_ready);
  modport slave(input out_data, out_nbits, out_last, out_err, out_valid, output out_ready);
endinterface

// File: rtl/edecfifo_213.sv
// edecfifo_213: first-word-fall-through FIFO; head is zero while empty
module edecfifo_213 #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic wr_en,
  input  logic [W-1:0] wr_data,
  input  logic rd_en,
  output logic [W-1:0] rd_data,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  always_ff @(posedge clock)
    if (do_wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/edecout_213.sv
// edecout_213: packs the serial decoded bit stream into tagged words and queues them for the host
module edecout_213
  import edecout_213_pkg::*;
#(
  parameter int PACK_W = PACK_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int BLOCK_BITS = BLOCK_BITS_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic Dx,
  input  logic Dx_oe,
  input  logic error,
  input  logic flush,
  edecout_213_if.master ob,
  output logic overflow
);
  localparam int WW = word_w(PACK_W);
  localparam int BW = $clog2(BLOCK_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [PACK_W-1:0] shreg, sh_n;
  logic [NB_W-1:0] fill, fill_n;
  logic [BW-1:0] blk_cnt, blk_base, blk_n;
  logic err_acc, err_q, err_n, blk_hit, push, full, empty;
  logic [WW-1:0] word, head;
  logic [AW:0] count_unused;
  // a rising error edge restarts block numbering; the bit of that cycle is the new block's first
  always_comb begin
    sh_n = Dx_oe ? {shreg[PACK_W-2:0], Dx} : shreg;
    fill_n = fill + NB_W'(Dx_oe);
    blk_base = (error && !err_q) ? '0 : blk_cnt;
    blk_hit = Dx_oe && blk_base == BW'(BLOCK_BITS - 1);
    blk_n = blk_hit ? '0 : blk_base + BW'(Dx_oe);
    err_n = err_acc || error;
    push = fill_n == NB_W'(PACK_W) || blk_hit || (flush && fill_n != '0);
    word = {sh_n, fill_n, blk_hit, err_n};
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      shreg <= '0;
      fill <= '0;
      blk_cnt <= '0;
      err_acc <= 1'b0;
      err_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      shreg <= push ? '0 : sh_n;
      fill <= push ? '0 : fill_n;
      err_acc <= !push && err_n;
      blk_cnt <= blk_n;
      err_q <= error;
      overflow <= overflow || (push && full && !ob.out_ready);
    end
  edecfifo_213 #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .wr_en(push),
    .wr_data(word),
    .rd_en(ob.out_ready),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count_unused)
  );
  assign ob.out_valid = !empty;
  assign ob.out_data = head[DATA_LO +: PACK_W];
  assign ob.out_nbits = head[NB_LO +: NB_W];
  assign ob.out_last = head[LAST_B];
  assign ob.out_err = head[ERR_B];
endmodule

// File: tb/tb_edecout_213.sv
// tb_edecout_213: directed checks of packing, flush, block tagging, overflow, error tagging and async reset
module tb_edecout_213;
  logic clock = 1'b0, reset = 1'b0, Dx = 1'b0, Dx_oe = 1'b0, error = 1'b0, flush = 1'b0;
  logic overflow;
  int checks = 0, errors = 0;
  edecout_213_if #(.PACK_W(8)) ob ();
  edecout_213 #(.PACK_W(8), .FIFO_DEPTH(4), .BLOCK_BITS(12)) dut (
    .clock(clock),
    .reset(reset),
    .Dx(Dx),
    .Dx_oe(Dx_oe),
    .error(error),
    .flush(flush),
    .ob(ob),
    .overflow(overflow)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic bit_in(input logic b, input logic e = 1'b0);
    Dx = b;
    Dx_oe = 1'b1;
    error = e;
    tick();
    Dx = 1'b0;
    Dx_oe = 1'b0;
    error = 1'b0;
  endtask
  task automatic byte_in(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_in(v[i]);
  endtask
  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  task automatic head(input string tag, input logic [7:0] d, input logic [3:0] n, input logic l, input logic e);
    check({tag, ".valid"}, ob.out_valid, 1'b1);
    check({tag, ".data"}, ob.out_data, d);
    check({tag, ".nbits"}, ob.out_nbits, n);
    check({tag, ".last"}, ob.out_last, l);
    check({tag, ".err"}, ob.out_err, e);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ob.out_ready = 1'b1;
    do_reset();
    check("rst.valid", ob.out_valid, 1'b0);
    check("rst.data", ob.out_data, 8'h00);
    check("rst.nbits", ob.out_nbits, 4'd0);
    check("rst.last", ob.out_last, 1'b0);
    check("rst.err", ob.out_err, 1'b0);
    check("rst.ovf", overflow, 1'b0);
    // full word, valid for exactly one cycle
    for (int i = 0; i < 7; i++) bit_in(8'hB2 >> (7 - i));
    check("w1.early", ob.out_valid, 1'b0);
    bit_in(1'b0);
    head("w1", 8'hB2, 4'd8, 1'b0, 1'b0);
    tick();
    check("w1.gone", ob.out_valid, 1'b0);
    // flush of a partial word, then an empty flush
    do_reset();
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    do_flush();
    head("fl", 8'h06, 4'd3, 1'b0, 1'b0);
    tick();
    do_flush();
    check("fl.empty", ob.out_valid, 1'b0);
    // block tagging with BLOCK_BITS=12
    do_reset();
    for (int i = 0; i < 8; i++) bit_in(i % 2 == 0);
    head("blk0", 8'hAA, 4'd8, 1'b0, 1'b0);
    for (int i = 8; i < 12; i++) bit_in(i % 2 == 0);
    head("blk1", 8'h0A, 4'd4, 1'b1, 1'b0);
    byte_in(8'hFF);
    head("blk2", 8'hFF, 4'd8, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_in(1'b1);
    head("blk3", 8'h0F, 4'd4, 1'b1, 1'b0);
    // overflow: four entries stored, fifth word dropped
    do_reset();
    ob.out_ready = 1'b0;
    byte_in(8'h12);
    byte_in(8'h34);
    byte_in(8'h56);
    check("ovf.at4", overflow, 1'b0);
    byte_in(8'h78);
    check("ovf.set", overflow, 1'b1);
    ob.out_ready = 1'b1;
    head("dr0", 8'h12, 4'd8, 1'b0, 1'b0);
    tick();
    head("dr1", 8'h03, 4'd4, 1'b1, 1'b0);
    tick();
    head("dr2", 8'h45, 4'd8, 1'b0, 1'b0);
    tick();
    head("dr3", 8'h06, 4'd4, 1'b1, 1'b0);
    tick();
    check("dr.empty", ob.out_valid, 1'b0);
    check("ovf.sticky", overflow, 1'b1);
    // async reset mid-word with two words queued
    ob.out_ready = 1'b0;
    byte_in(8'h11);
    for (int i = 0; i < 6; i++) bit_in(1'b1);
    check("ar.before", ob.out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("ar.valid", ob.out_valid, 1'b0);
    check("ar.ovf", overflow, 1'b0);
    check("ar.data", ob.out_data, 8'h00);
    tick();
    reset = 1'b1;
    ob.out_ready = 1'b1;
    byte_in(8'hE7);
    head("ar.word", 8'hE7, 4'd8, 1'b0, 1'b0);
    // error during the third bit tags that word and restarts block numbering
    do_reset();
    for (int i = 7; i >= 0; i--) bit_in(8'hC3 >> i, i == 5);
    head("er0", 8'hC3, 4'd8, 1'b0, 1'b1);
    for (int i = 7; i >= 3; i--) bit_in(8'h5A >> i);
    check("er.mid", ob.out_valid, 1'b0);
    bit_in(1'b0);
    head("er1", 8'h16, 4'd6, 1'b1, 1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    do_flush();
    head("er2", 8'h02, 4'd2, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/edecout_213.md
Name: edecout_213

Overview:
- Output stage of the efficient (2,1,3) Viterbi decoder, directly downstream of the metric-update/control unit.
- Accepts the serial decoded bit stream (Dx qualified by Dx_oe) and the out-of-sync error flag.
- Packs the bits into words, tags block boundaries and error conditions, and buffers the words in a small FIFO.
- Presents the FIFO contents on a valid/ready interface to the host side.

Parameters:
- PACK_W, 8, decoded bits per output word.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- BLOCK_BITS, 256, decoded bits per pseudo-block; the last word of each block is tagged.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Dx  input  `k (1)  decoded bit; high-Z unless Dx_oe is high.
- Dx_oe  input  1  Dx valid strobe, at most one bit per cycle.
- error  input  1  out-of-sync error from the decoder.
- flush  input  1  single-cycle request to emit the partial word now.
- out_data  output  PACK_W  packed bits; first-received bit in the MSB of the valid field, right-aligned.
- out_nbits  output  4  number of valid bits in out_data, 1..PACK_W.
- out_last  output  1  word closes a pseudo-block.
- out_err  output  1  error was seen while this word accumulated.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the word this cycle.
- overflow  output  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): packer, bit counters and FIFO are cleared.
  - Outputs after reset: out_valid=0, out_data=0, out_nbits=0, out_last=0, out_err=0, overflow=0.
- Sampling rule: Dx is sampled only in cycles where Dx_oe=1. Dx is never read otherwise, because it is Z.
- Packer state:
  - shreg[PACK_W-1:0], fill[3:0], blk_cnt (clog2(BLOCK_BITS) bits), err_acc.
- Bit capture: when Dx_oe=1:
  - shreg <= {shreg[PACK_W-2:0], Dx};
  - fill <= fill+1;
  - blk_cnt <= blk_cnt+1.
- Push conditions, evaluated on the post-capture state:
  - (a) fill reaches PACK_W;
  - (b) blk_cnt reaches BLOCK_BITS; this sets last=1 and wraps blk_cnt to 0;
  - (c) flush=1 with fill>0, counting a bit captured in the same cycle.
  - If (a) and (b) coincide, one word is pushed with last=1.
  - flush with fill=0 and no capture: no push.
- Pushed word: {shreg (right-aligned), nbits=fill, last, err_acc or error}.
  - After a push: fill, shreg and err_acc clear.
  - A bit arriving in the push cycle is included in the pushed word, never lost.
- Error:
  - error=1 sets err_acc; it clears on the next push.
  - Rising edge of error additionally resets blk_cnt to 0, which resynchronises block tagging. The partial word is still kept.
- FIFO behaviour: first-word-fall-through.
  - out_* fields are driven from the head entry.
  - A pop occurs when out_valid && out_ready.
- Latency: the push in cycle N makes out_valid=1 in cycle N+1 if the FIFO was empty.
- Simultaneous push and pop:
  - When full, a push and a pop in the same cycle both succeed and occupancy is unchanged.
  - When empty, a push and a pop in the same cycle: the pop is ignored because out_valid=0.
- Full with push and no pop: the word is dropped, overflow is set and stays set until reset. Stored entries are untouched.
- Pointer and count widths:
  - Pointers are clog2(FIFO_DEPTH) bits, wrapping naturally.
  - The count is clog2(FIFO_DEPTH)+1 bits.
- Reset mid-word or mid-block discards all state. No partial output is emitted.

Decomposition:
- params_e213.inc gains `PACK_W and `OUT_FIFO_DEPTH defaults. The existing `k is used for the Dx width.
- Word field layout is defined once as macros in the same include: data, nbits, last, err.
- One sub-module, edecfifo_213:
  - synchronous FWFT FIFO, parameterised width and depth;
  - same clock and active-low asynchronous reset;
  - provides full, empty and count.
- The packer stays in the top module.

Test Plan:
- 8 consecutive Dx_oe pulses with bits 1,0,1,1,0,0,1,0 and out_ready=1 -> one word with out_data=8'hB2, nbits=8, last=0, err=0; out_valid high exactly 1 cycle, the cycle after the 8th bit.
- 3 bits 1,1,0, then flush -> out_data=8'h06, nbits=3. A second flush with fill=0 -> no word.
- BLOCK_BITS=12, 12 bits of alternating 1,0 -> words 8'hAA (nbits=8, last=0) then 8'h0A (nbits=4, last=1); the 13th bit starts a new block.
- out_ready=0, 5×8 bits (FIFO_DEPTH=4) -> first 4 words retained in order, 5th dropped, overflow=1 sticky. Then out_ready=1 drains the 4 words intact.
- error pulsed during bit 3 of a word -> that word has out_err=1 and the next word out_err=0; blk_cnt restarts, so last lands BLOCK_BITS bits after the error edge.
- reset asserted low mid-word with 2 words queued -> out_valid=0 and overflow=0 immediately, without waiting for a clock edge. Next 8 bits produce a clean first word.
